// File: rtl/sflash_x.sv
// sflash_x: SDR/dual/quad SPI flash byte engine with mode-3 SCLK and multiple chip selects.
// Define SFLASH_X_DUMMY_EN to build the dummy-cycle phase; otherwise `dummy` is ignored.
module sflash_x #(
  parameter int PRESCALE_W = 4,
  parameter int NCS        = 1
) (
  input  logic                  clk,
  input  logic                  arstn,
  output logic                  ready,
  input  logic                  wr,
  input  logic [7:0]            din,
  input  logic [2:0]            format,
  input  logic [3:0]            dummy,
  input  logic [NCS-1:0]        cs_mask,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  output logic                  sclk,
  output logic [NCS-1:0]        cs_n,
  input  logic [3:0]            qdi,
  output logic [3:0]            qdo,
  output logic [3:0]            oe
);
  typedef enum logic [1:0] {IDLE, DUMMY, SHIFT, LAST} state_t;

  typedef struct packed {
    logic [2:0]            fmt;
    logic [PRESCALE_W-1:0] pre;
  } cfg_t;

  state_t                state;
  cfg_t                  cfg;
  logic [7:0]            sr;
  logic [3:0]            cnt;
  logic [PRESCALE_W-1:0] div;
  logic                  start;
  logic                  tick;
  logic [7:0]            sr_shifted;
  logic [3:0]            qdo_next;

`ifndef SFLASH_X_DUMMY_EN
  logic unused_dummy;
  assign unused_dummy = ^dummy;
`endif

  function automatic logic [3:0] groups(input logic [2:0] f);
    case (f[2:1])
      2'b01:   return 4'd8;
      2'b10:   return 4'd4;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [3:0] shift_oe(input logic [2:0] f);
    case (f)
      3'b010, 3'b011: return 4'b0001;
      3'b100:         return 4'b0011;
      3'b110:         return 4'b1111;
      default:        return 4'b0000;
    endcase
  endfunction

  // CS follows the live format/mask so the host can hold it low across bytes.
  assign cs_n  = (format[2:1] != 2'b00) ? ~cs_mask : '1;
  assign start = (state == IDLE) && wr && (format[2:1] != 2'b00);
  assign tick  = ((state == DUMMY) || (state == SHIFT)) && (div == '0);

  always_comb begin
    sr_shifted = sr;
    qdo_next   = qdo;
    case (cfg.fmt[2:1])
      2'b01: begin
        sr_shifted  = {sr[6:0], qdi[1]};
        qdo_next[0] = sr[7];
      end
      2'b10: begin
        sr_shifted    = {sr[5:0], qdi[1:0]};
        qdo_next[1:0] = sr[7:6];
      end
      default: begin
        sr_shifted = {sr[3:0], qdi};
        qdo_next   = sr[7:4];
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state      <= IDLE;
      cfg        <= '0;
      sr         <= '0;
      cnt        <= '0;
      div        <= '0;
      ready      <= 1'b1;
      sclk       <= 1'b1;
      qdo        <= '0;
      oe         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sr    <= din;
            cfg   <= '{fmt: format, pre: prescale};
            div   <= prescale;
            ready <= 1'b0;
`ifdef SFLASH_X_DUMMY_EN
            if (dummy != 4'd0) begin
              state <= DUMMY;
              cnt   <= dummy;
            end else
`endif
            begin
              state <= SHIFT;
              cnt   <= groups(format);
              oe    <= shift_oe(format);
            end
          end
        end
        DUMMY, SHIFT: begin
          if (!tick) begin
            div <= div - 1'b1;
          end else begin
            div  <= cfg.pre;
            sclk <= ~sclk;
            if (sclk) begin
              // falling toggle: present the next group; dummy periods leave qdo alone
              if (state == SHIFT) qdo <= qdo_next;
            end else begin
              if (state == SHIFT) sr <= sr_shifted;
              if (cnt != 4'd1) begin
                cnt <= cnt - 1'b1;
              end else if (state == SHIFT) begin
                state <= LAST;
                oe    <= '0;
              end
`ifdef SFLASH_X_DUMMY_EN
              else begin
                state <= SHIFT;
                cnt   <= groups(cfg.fmt);
                oe    <= shift_oe(cfg.fmt);
              end
`endif
            end
          end
        end
        LAST: begin
          dout       <= sr;
          dout_valid <= 1'b1;
          ready      <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sflash_x.sv
// Bench for sflash_x: directed and random bytes checked against a per-byte reference model
// derived from the group/period arithmetic of the engine.
module tb_sflash_x;
  localparam int PW  = 4;
  localparam int NCS = 4;
`ifdef SFLASH_X_DUMMY_EN
  localparam bit DUMMY_EN = 1'b1;
`else
  localparam bit DUMMY_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           arstn = 1'b0;
  logic           ready;
  logic           wr = 1'b0;
  logic [7:0]     din = '0;
  logic [2:0]     format = '0;
  logic [3:0]     dummy = '0;
  logic [NCS-1:0] cs_mask = 4'b0001;
  logic [PW-1:0]  prescale = '0;
  logic [7:0]     dout;
  logic           dout_valid;
  logic           sclk;
  logic [NCS-1:0] cs_n;
  logic [3:0]     qdi = '0;
  logic [3:0]     qdo;
  logic [3:0]     oe;

  sflash_x #(.PRESCALE_W(PW), .NCS(NCS)) dut (
    .clk(clk), .arstn(arstn), .ready(ready), .wr(wr), .din(din), .format(format),
    .dummy(dummy), .cs_mask(cs_mask), .prescale(prescale), .dout(dout),
    .dout_valid(dout_valid), .sclk(sclk), .cs_n(cs_n), .qdi(qdi), .qdo(qdo), .oe(oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_rise_cyc = 0;
  int first_fall_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next qdi value, given the number of rising edges already seen.
  function automatic logic [3:0] pick(input int mode, input int r, input int de);
    if (mode == 2 && r == de)     return 4'hC;
    if (mode == 2 && r == de + 1) return 4'h3;
    return 4'($urandom);
  endfunction

  // mode 0: random qdi, 1: qdi[1] loops back qdo[0], 2: data samples C then 3
  task automatic xfer(input logic [7:0] d, input logic [2:0] f, input int p, input int dm,
                      input int mode, input bit busy_poke, input bit gap_chk, input string tag);
    int de, w, n, t, rises, falls, low, ff, vcnt, qdo_bad, oe_bad, dd, prior_rise;
    logic [3:0] mask, exp_oe, oe_shift, q0;
    logic [7:0] exp_d;
    logic prev;
    de = DUMMY_EN ? dm : 0;
    w  = (f[2:1] == 2'b01) ? 1 : (f[2:1] == 2'b10) ? 2 : 4;
    n  = 8 / w;
    mask = 4'((1 << w) - 1);
    oe_shift = (f[2] && f[0]) ? 4'b0000 : mask;
    dd = int'(d);
    q0 = qdo;
    exp_d = '0;
    prior_rise = last_rise_cyc;
    din = d; format = f; prescale = PW'(p); dummy = 4'(dm); wr = 1'b1;
    qdi = pick(mode, 0, de);
    @(posedge clk); #1;
    // scramble everything that must have been latched
    wr = 1'b0; din = ~d; prescale = PW'(~p); dummy = 4'(~dm); format = {f[2:1], ~f[0]};
    t = 0; rises = 0; falls = 0; low = 0; ff = -1; vcnt = 0; qdo_bad = 0; oe_bad = 0;
    prev = 1'b1;
    while (t < 4000) begin
      if (sclk !== prev) begin
        prev = sclk;
        if (sclk === 1'b0) begin
          falls++;
          if (ff < 0) begin ff = t; first_fall_cyc = cyc; end
          if (falls <= de) begin
            if (qdo !== q0) qdo_bad++;
          end else if ((qdo & mask) !== 4'((dd >> (8 - w * (falls - de))) & int'(mask))) begin
            qdo_bad++;
          end
          if (mode == 1) qdi[1] = qdo[0];
        end else begin
          rises++;
          last_rise_cyc = cyc;
          if (rises > de)
            exp_d = 8'((int'(exp_d) << w) | ((w == 1) ? int'(qdi[1]) : int'(qdi & mask)));
          if (mode != 1) qdi = pick(mode, rises, de);
        end
      end
      exp_oe = (ready === 1'b0 && rises >= de && rises < de + n) ? oe_shift : 4'b0000;
      if (oe !== exp_oe) oe_bad++;
      if (dout_valid === 1'b1) vcnt++;
      if (ready !== 1'b0) break;
      low++;
      if (busy_poke && t == 2) begin wr = 1'b1; din = 8'h3C; end
      else wr = 1'b0;
      @(posedge clk); #1;
      t++;
    end
    wr = 1'b0;
    chk({tag, "_timeout"}, 32'(t < 4000), 32'd1);
    chk({tag, "_ready_low"}, low, 2 * (de + n) * (p + 1) + 1);
    chk({tag, "_falls"}, falls, de + n);
    chk({tag, "_rises"}, rises, de + n);
    chk({tag, "_first_fall"}, ff, p + 1);
    chk({tag, "_qdo"}, qdo_bad, 0);
    chk({tag, "_oe"}, oe_bad, 0);
    chk({tag, "_valid_at_ready"}, 32'(dout_valid), 32'd1);
    chk({tag, "_valid_count"}, vcnt, 1);
    chk({tag, "_dout"}, 32'(dout), 32'(exp_d));
    if (gap_chk) chk({tag, "_gap"}, 32'((first_fall_cyc - prior_rise) >= p + 2), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [2:0] f;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_qdo", 32'(qdo), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_valid", 32'(dout_valid), 32'd0);
    arstn = 1'b1;
    @(posedge clk); #1;
    chk("cs_idle", 32'(cs_n), 32'hF);
    cs_mask = 4'b0100; format = 3'b010;
    #1;
    chk("cs_sel", 32'(cs_n), 32'hB);

    // wr with inactive format must be ignored
    format = 3'b000; wr = 1'b1; din = 8'hFF; bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || sclk !== 1'b1) bad++;
    end
    wr = 1'b0;
    chk("ign_fmt0", bad, 0);
    cs_mask = 4'b0001;

    xfer(8'hA5, 3'b010, 0, 0, 1, 1'b0, 1'b0, "sdr_loop");
    chk("sdr_dout_a5", 32'(dout), 32'hA5);
    xfer(8'h5E, 3'b111, 3, 2, 2, 1'b0, 1'b0, "quad_rx");
    chk("quad_dout_c3", 32'(dout), 32'hC3);
    xfer(8'h1B, 3'b100, 1, 0, 0, 1'b0, 1'b0, "dual_tx");
    xfer(8'hE7, 3'b011, 2, 1, 1, 1'b1, 1'b0, "busy_wr");
    chk("busy_dout_e7", 32'(dout), 32'hE7);

    // reset in the middle of a quad send
    din = 8'h96; format = 3'b110; prescale = PW'(1); dummy = 4'd0; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    arstn = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_sclk", 32'(sclk), 32'd1);
    chk("arst_qdo", 32'(qdo), 32'd0);
    chk("arst_oe", 32'(oe), 32'd0);
    chk("arst_dout", 32'(dout), 32'd0);
    chk("arst_valid", 32'(dout_valid), 32'd0);
    @(posedge clk); #1;
    chk("arst_hold_sclk", 32'(sclk), 32'd1);
    arstn = 1'b1;
    @(posedge clk); #1;
    xfer(8'h69, 3'b110, 1, 0, 0, 1'b0, 1'b0, "post_rst");

    xfer(8'hC1, 3'b010, 2, 0, 1, 1'b0, 1'b0, "b2b_a");
    xfer(8'h7D, 3'b100, 2, 1, 0, 1'b0, 1'b1, "b2b_b");

    for (int i = 0; i < 12; i++) begin
      f = 3'(2 + $urandom_range(0, 5));
      xfer(8'($urandom), f, $urandom_range(0, 5), $urandom_range(0, 4), 0, 1'b0, 1'b1,
           $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
